// File: rtl/button_conditioner.sv
// Per-channel pushbutton conditioning: 2-FF synchronizer, counter debouncer,
// registered press/release pulses and a once-per-press long-press pulse.
module button_conditioner #(
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = 250_000,
    parameter int LONG_CYCLES = 25_000_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic             any_press
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int LW  = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [N_BTN-1:0] REL_RAW   = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};
    localparam logic [DBW-1:0]   DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [LW-1:0]    LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] long_q, long_d;
    logic [N_BTN-1:0] fired_q, fired_d;
    logic             any_q, any_d;

    logic [N_BTN-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [N_BTN-1:0][LW-1:0]  l_cnt_q, l_cnt_d;

    logic [N_BTN-1:0] pressed;

    // Synchronized pin re-expressed as 1 = pressed regardless of pin polarity.
    assign pressed = s2_q ^ REL_RAW;

    always_comb begin
        s1_d      = btn_raw;
        s2_d      = s1_q;
        level_d   = level_q;
        db_cnt_d  = db_cnt_q;
        l_cnt_d   = l_cnt_q;
        fired_d   = fired_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;

        for (int i = 0; i < N_BTN; i++) begin
            if (pressed[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = ~level_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end

            press_d[i]   = level_d[i] & ~level_q[i];
            release_d[i] = ~level_d[i] & level_q[i];

            // Counter holds once fired so an endless hold never repeats the pulse.
            if (press_d[i]) begin
                l_cnt_d[i] = '0;
                fired_d[i] = 1'b0;
            end else if (!level_q[i]) begin
                l_cnt_d[i] = '0;
            end else if (!fired_q[i]) begin
                if (l_cnt_q[i] == LONG_LAST) begin
                    long_d[i]  = 1'b1;
                    fired_d[i] = 1'b1;
                end else begin
                    l_cnt_d[i] = l_cnt_q[i] + 1'b1;
                end
            end
        end

        any_d = |press_d;
    end

    // Synchronizers reset to the released pin level so reset exit is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= REL_RAW;
            s2_q      <= REL_RAW;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            fired_q   <= '0;
            any_q     <= 1'b0;
            db_cnt_q  <= '0;
            l_cnt_q   <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            fired_q   <= fired_d;
            any_q     <= any_d;
            db_cnt_q  <= db_cnt_d;
            l_cnt_q   <= l_cnt_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign any_press     = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (N_BTN=2, DB_CYCLES=4, LONG_CYCLES=16, active-low pins).
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic       any_press;

    typedef struct {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
        logic [1:0] lv;
        logic       an;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   base     = 0;
    int   checks   = 0;
    int   failures = 0;

    button_conditioner #(
        .N_BTN      (2),
        .DB_CYCLES  (4),
        .LONG_CYCLES(16),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .any_press    (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to timestamp every expected event.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Pins change just after a falling edge; the next rising edge is edge 1.
    task automatic applyStimulus(input logic [1:0] raw);
        @(negedge clk);
        btn_raw = raw;
        base    = cyc;
    endtask

    task automatic expectEvent(input int ofs, input logic [1:0] pr, input logic [1:0] rl,
                               input logic [1:0] lg, input logic [1:0] lv, input logic an);
        exp_t e;
        e.cyc = base + ofs;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        e.lv  = lv;
        e.an  = an;
        sb.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse activity must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if ((press_pulse | release_pulse | long_pulse) != 2'b00 || any_press) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", int'({long_pulse, release_pulse, press_pulse}), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_cycle", cyc, e.cyc);
                checkOutput("press_pulse", int'(press_pulse), int'(e.pr));
                checkOutput("release_pulse", int'(release_pulse), int'(e.rl));
                checkOutput("long_pulse", int'(long_pulse), int'(e.lg));
                checkOutput("btn_level", int'(btn_level), int'(e.lv));
                checkOutput("any_press", int'(any_press), int'(e.an));
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checkOutput("missed_event_cycle", cyc, e.cyc);
        end
    end

    initial begin
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        waitCycles(3);
        checkOutput("reset_level", int'(btn_level), 0);
        checkOutput("reset_press", int'(press_pulse), 0);
        checkOutput("reset_release", int'(release_pulse), 0);
        checkOutput("reset_long", int'(long_pulse), 0);
        checkOutput("reset_any", int'(any_press), 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(8);

        // Clean press on channel 0, then release before the long threshold.
        applyStimulus(2'b10);
        expectEvent(6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        waitCycles(10);
        checkOutput("held_level", int'(btn_level), 1);
        applyStimulus(2'b11);
        expectEvent(6, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        waitCycles(12);

        // Three-cycle glitch is swallowed; four-cycle low is accepted.
        applyStimulus(2'b10);
        waitCycles(2);
        applyStimulus(2'b11);
        waitCycles(10);
        checkOutput("glitch_level", int'(btn_level), 0);
        applyStimulus(2'b10);
        expectEvent(6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        expectEvent(10, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        waitCycles(3);
        applyStimulus(2'b11);
        waitCycles(15);

        // Long press on channel 1 fires exactly once 16 edges after the press edge.
        applyStimulus(2'b01);
        expectEvent(6, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1);
        expectEvent(22, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0);
        waitCycles(39);
        applyStimulus(2'b11);
        expectEvent(6, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        waitCycles(12);

        // Both channels pressed together, released before long threshold.
        applyStimulus(2'b00);
        expectEvent(6, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        waitCycles(8);
        applyStimulus(2'b11);
        expectEvent(6, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        waitCycles(12);

        // Reset mid-press clears immediately; held button re-presses after release of reset.
        applyStimulus(2'b10);
        expectEvent(6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        waitCycles(9);
        checkOutput("pre_reset_level", int'(btn_level), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_level", int'(btn_level), 0);
        checkOutput("async_reset_pulses", int'({long_pulse, release_pulse, press_pulse}), 0);
        waitCycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        expectEvent(6, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        waitCycles(10);
        applyStimulus(2'b11);
        expectEvent(6, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        waitCycles(12);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
